decode_queue: RTL and testbench

//  Buffered, parametrised decode stage for the breadboard CPU. Accepts a stream of instruction words
//  (opcode words and extension words on one port), pairs each extended opcode with its extension word,

---
 rtl/decode_queue.sv | 93 +++++++++
 tb/tb_decode_queue.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/decode_queue.sv
// decode_queue: pairs opcode/extension words, buffers up to DEPTH instructions
// and presents the head as decoded control strobes behind a valid/ready handshake.
module decode_queue #(
   parameter  int DEPTH = 4,
   parameter  int ARG_W = 5,
   parameter  int SRC_W = 4,
   localparam int W     = 7 + ARG_W + SRC_W,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic             cpu_clk,
   input  logic             cpu_rst,
   input  logic [W-1:0]     ins,
   input  logic             ins_valid,
   output logic             ins_ready,
   input  logic             flush,
   output logic             dec_valid,
   input  logic             dec_ready,
   output logic             read_a,
   output logic             imm5_a,
   output logic [ARG_W-1:0] arg_a,
   output logic             read_b,
   output logic [SRC_W-1:0] src_b,
   output logic             set_pc,
   output logic             add_pc,
   output logic [2:0]       cmp_b,
   output logic [W-1:0]     ext_word,
   output logic             illegal,
   output logic [AW:0]      count
);
   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
   localparam int          EW   = 2*W - 1;
   typedef enum logic {IDLE, WAIT_EXT} state_t;
   state_t          r_state, w_state_nx;
   logic [W-2:0]    r_hold;
   logic [EW-1:0]   r_mem [DEPTH];
   logic [AW-1:0]   r_wr, r_rd;
   logic [AW:0]     r_count;
   logic            w_acc, w_push, w_pop, w_hold;
   logic [EW-1:0]   w_entry, w_head;
   logic [W-2:0]    w_op;
   logic [2:0]      w_cls;
   // Entries drop the opcode's ext bit: it is implied by ext_word being present.
   assign ins_ready = !cpu_rst && r_count != FULL;
   assign w_acc     = ins_valid && ins_ready && !flush;
   assign w_hold    = w_acc && r_state == IDLE && ins[W-1];
   assign w_push    = w_acc && !w_hold;
   assign w_pop     = dec_valid && dec_ready && !flush;
   assign w_entry   = r_state == WAIT_EXT ? {r_hold, ins} : {ins[W-2:0], {W{1'b0}}};
   always_comb begin
      w_state_nx = r_state;
      w_state_nx = flush ? IDLE : !w_acc ? r_state : w_hold ? WAIT_EXT : IDLE;
   end
   always_ff @(posedge cpu_clk or posedge cpu_rst) begin
      if (cpu_rst) begin
         r_state <= IDLE;
         r_hold  <= '0;
         r_wr    <= '0;
         r_rd    <= '0;
         r_count <= '0;
      end else begin
         r_state <= w_state_nx;
         if (flush) begin
            r_hold  <= '0;
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
         end else begin
            if (w_hold) r_hold <= ins[W-2:0];
            if (w_push) r_wr <= r_wr + AW'(1);
            if (w_pop) r_rd <= r_rd + AW'(1);
            r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
         end
      end
   end
   always_ff @(posedge cpu_clk) begin
      if (w_push) r_mem[r_wr] <= w_entry;
   end
   assign dec_valid = r_count != '0;
   assign count     = r_count;
   assign w_head    = r_mem[r_rd];
   assign w_op      = w_head[EW-1:W];
   assign w_cls     = w_op[W-2 -: 3];
   assign read_a    = dec_valid && w_cls == 3'd0;
   assign imm5_a    = dec_valid && w_cls == 3'd1;
   assign read_b    = dec_valid && w_cls <= 3'd1;
   assign set_pc    = dec_valid && w_cls == 3'd2;
   assign add_pc    = dec_valid && w_cls == 3'd3;
   assign illegal   = dec_valid && w_cls >= 3'd5;
   assign arg_a     = dec_valid ? w_op[ARG_W+SRC_W+2 -: ARG_W] : '0;
   assign src_b     = dec_valid ? w_op[SRC_W+2 -: SRC_W] : '0;
   assign cmp_b     = dec_valid ? w_op[2:0] : '0;
   assign ext_word  = dec_valid ? w_head[W-1:0] : '0;
endmodule

// File: tb/tb_decode_queue.sv
// tb_decode_queue: table vectors, directed corner sequences and random traffic
// checked against a queue-based model of the decode stage.
module tb_decode_queue;
   logic        cpu_clk = 0, cpu_rst = 1;
   logic [15:0] ins = 0;
   logic        ins_valid = 0, flush = 0, dec_ready = 0;
   logic        ins_ready, dec_valid, read_a, imm5_a, read_b, set_pc, add_pc, illegal;
   logic [4:0]  arg_a;
   logic [3:0]  src_b;
   logic [2:0]  cmp_b, count;
   logic [15:0] ext_word;
   int          checks = 0, fails = 0;
   logic [31:0] mq[$];
   logic        m_wait = 0;
   logic [15:0] m_hold = 0;
   typedef struct {logic [15:0] w; logic [5:0] f;} vec_t;
   vec_t tv[8];

   decode_queue dut (
      .cpu_clk(cpu_clk), .cpu_rst(cpu_rst), .ins(ins), .ins_valid(ins_valid),
      .ins_ready(ins_ready), .flush(flush), .dec_valid(dec_valid), .dec_ready(dec_ready),
      .read_a(read_a), .imm5_a(imm5_a), .arg_a(arg_a), .read_b(read_b), .src_b(src_b),
      .set_pc(set_pc), .add_pc(add_pc), .cmp_b(cmp_b), .ext_word(ext_word),
      .illegal(illegal), .count(count)
   );

   always #5 cpu_clk = ~cpu_clk;

   task automatic chk(input string n, input logic [63:0] g, input logic [63:0] e);
      checks++;
      if (g !== e) begin
         fails++;
         $display("FAIL %s got=%0h exp=%0h", n, g, e);
      end
   endtask

   function automatic logic [38:0] dut_out();
      return {dec_valid, read_a, imm5_a, arg_a, read_b, src_b, set_pc, add_pc, cmp_b,
              ext_word, illegal, count, ins_ready};
   endfunction

   function automatic logic [38:0] model_out();
      logic        dv;
      logic [15:0] op, ex;
      logic [2:0]  c;
      logic [5:0]  f;
      dv = mq.size() > 0;
      op = dv ? mq[0][31:16] : 16'h0;
      ex = dv ? mq[0][15:0] : 16'h0;
      c  = op[14:12];
      case (c)
         3'd0: f = 6'b101000;
         3'd1: f = 6'b011000;
         3'd2: f = 6'b000100;
         3'd3: f = 6'b000010;
         3'd4: f = 6'b000000;
         default: f = 6'b000001;
      endcase
      if (!dv) f = 6'b0;
      return {dv, f[5], f[4], op[11:7], f[3], op[6:3], f[2], f[1], op[2:0], ex, f[0],
              3'(mq.size()), mq.size() < 4};
   endfunction

   task automatic model_step(input logic v, input logic [15:0] w, input logic dr, input logic fl);
      logic acc, pop;
      acc = v && mq.size() < 4 && !fl;
      pop = mq.size() > 0 && dr && !fl;
      if (fl) begin
         mq.delete();
         m_wait = 0;
      end else begin
         if (pop) void'(mq.pop_front());
         if (acc) begin
            if (m_wait) begin
               mq.push_back({m_hold, w});
               m_wait = 0;
            end else if (w[15]) begin
               m_hold = w;
               m_wait = 1;
            end else mq.push_back({w, 16'h0});
         end
      end
   endtask

   // Drive one cycle: compare against the model, then clock and advance the model.
   task automatic cyc(input logic v, input logic [15:0] w, input logic dr, input logic fl);
      ins_valid = v; ins = w; dec_ready = dr; flush = fl;
      #1;
      chk("model", 64'(dut_out()), 64'(model_out()));
      model_step(v, w, dr, fl);
      @(posedge cpu_clk);
      #1;
   endtask

   function automatic logic [5:0] flags();
      return {read_a, imm5_a, read_b, set_pc, add_pc, illegal};
   endfunction

   initial begin
      tv[0] = '{16'h05A3, 6'b101000};
      tv[1] = '{16'h15A3, 6'b011000};
      tv[2] = '{16'h25A3, 6'b000100};
      tv[3] = '{16'h35A3, 6'b000010};
      tv[4] = '{16'h45A3, 6'b000000};
      tv[5] = '{16'h55A3, 6'b000001};
      tv[6] = '{16'h65A3, 6'b000001};
      tv[7] = '{16'h75A3, 6'b000001};
      #1;
      chk("rst_ready", 64'(ins_ready), 0);
      chk("rst_valid", 64'(dec_valid), 0);
      chk("rst_count", 64'(count), 0);
      repeat (2) @(posedge cpu_clk);
      @(negedge cpu_clk) cpu_rst = 0;
      #1 chk("rel_ready", 64'(ins_ready), 1);
      @(posedge cpu_clk); #1;
      // single ALU_IR word
      cyc(1, 16'h1A5C, 0, 0);
      chk("t2_valid", 64'(dec_valid), 1);
      chk("t2_flags", 64'(flags()), 64'(6'b011000));
      chk("t2_fields", 64'({arg_a, src_b, cmp_b, ext_word}), 64'({5'h14, 4'hB, 3'd4, 16'h0}));
      cyc(0, 0, 1, 0);
      // JMP with extension word
      cyc(1, 16'hA000, 0, 0);
      chk("t3_wait_valid", 64'(dec_valid), 0);
      cyc(1, 16'h1234, 0, 0);
      chk("t3_set_pc", 64'(set_pc), 1);
      chk("t3_ext", 64'(ext_word), 64'h1234);
      cyc(0, 0, 1, 0);
      // class table
      for (int i = 0; i < 8; i++) begin
         cyc(1, tv[i].w, 0, 0);
         chk($sformatf("tab%0d_flags", i), 64'(flags()), 64'(tv[i].f));
         chk($sformatf("tab%0d_fields", i), 64'({arg_a, src_b, cmp_b}), 64'(tv[i].w[11:0]));
         chk($sformatf("tab%0d_count", i), 64'(count), 1);
         cyc(0, 0, 1, 0);
      end
      // fill to DEPTH, fifth word held until space frees
      for (int i = 1; i <= 4; i++) cyc(1, 16'(16'h4000 + i), 0, 0);
      chk("t4_full_count", 64'(count), 4);
      chk("t4_full_ready", 64'(ins_ready), 0);
      cyc(1, 16'h4005, 0, 0);
      chk("t4_held_count", 64'(count), 4);
      cyc(1, 16'h4005, 1, 0);
      chk("t4_pop_count", 64'(count), 3);
      cyc(1, 16'h4005, 0, 0);
      chk("t4_refill_count", 64'(count), 4);
      for (int i = 2; i <= 5; i++) begin
         chk($sformatf("t4_order%0d", i), 64'(cmp_b), 64'(i));
         cyc(0, 0, 1, 0);
      end
      chk("t4_empty", 64'(count), 0);
      // flush during WAIT_EXT drops the pending opcode and the same-edge word
      cyc(1, 16'hA000, 0, 0);
      cyc(1, 16'h0001, 0, 1);
      chk("t5_flush_count", 64'(count), 0);
      cyc(1, 16'h4000, 0, 0);
      chk("t5_nop", 64'({dec_valid, count, flags(), ext_word}), 64'({1'b1, 3'd1, 6'b0, 16'h0}));
      cyc(0, 0, 1, 0);
      // reserved class, then simultaneous push and pop
      cyc(1, 16'h6000, 0, 0);
      chk("t6_illegal", 64'(flags()), 64'(6'b000001));
      cyc(1, 16'h1A5C, 0, 0);
      chk("t6_count2", 64'(count), 2);
      cyc(1, 16'h4003, 1, 0);
      chk("t6_pushpop_count", 64'(count), 2);
      chk("t6_head", 64'(imm5_a), 1);
      cyc(0, 0, 1, 0);
      cyc(0, 0, 1, 0);
      // asynchronous reset mid-instruction
      cyc(1, 16'h1111, 0, 0);
      cyc(1, 16'hA000, 0, 0);
      ins_valid = 0;
      #2 cpu_rst = 1;
      #1;
      chk("t1_valid", 64'(dec_valid), 0);
      chk("t1_count", 64'(count), 0);
      chk("t1_ready", 64'(ins_ready), 0);
      mq.delete();
      m_wait = 0;
      @(negedge cpu_clk) cpu_rst = 0;
      #1 chk("t1_rel_ready", 64'(ins_ready), 1);
      @(posedge cpu_clk); #1;
      cyc(1, 16'h4000, 0, 0);
      chk("t1_nop", 64'({dec_valid, count, flags()}), 64'({1'b1, 3'd1, 6'b0}));
      for (int i = 0; i < 3000; i++)
         cyc($urandom_range(0, 3) != 0, 16'($urandom), $urandom_range(0, 1) == 1,
             $urandom_range(0, 19) == 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end
endmodule
